// File: rtl/pipe_logic_array_if.sv
// rtl/pipe_logic_array_if.sv - input/output handshake bundle for pipe_logic_array
interface pipe_logic_array_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output in_valid, in1, in2, mode, out_ready,
    input  in_ready, out_valid, out, xfer_cnt
  );

  modport slave (
    input  in_valid, in1, in2, mode, out_ready,
    output in_ready, out_valid, out, xfer_cnt
  );
endinterface

// File: rtl/pipe_logic_array.sv
// rtl/pipe_logic_array.sv - lane-wise logic function pipeline with valid/ready flow control
module pipe_logic_array #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  pipe_logic_array_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] opb_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] func;
  logic             advance;
  logic             out_fire;

  // Stage 0 keeps operand A in its data field, operand B and mode alongside.
  always_comb begin
    func = '0;
    unique case (mode_q)
      2'd0:    func = ~(data_q[0] & ~opb_q);
      2'd1:    func = data_q[0] & opb_q;
      2'd2:    func = data_q[0] ^ opb_q;
      default: func = ~(data_q[0] | opb_q);
    endcase
  end

  assign advance  = ~(valid_q[DEPTH-1] & ~bus.out_ready);
  assign out_fire = valid_q[DEPTH-1] & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
      opb_q  <= '0;
      mode_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (advance) begin
        valid_q <= {valid_q[DEPTH-2:0], bus.in_valid};
        if (bus.in_valid) begin
          data_q[0] <= bus.in1;
          opb_q     <= bus.in2;
          mode_q    <= bus.mode;
        end
        data_q[1] <= func;
        for (int k = 2; k < DEPTH; k++) begin
          data_q[k] <= data_q[k-1];
        end
      end
      if (out_fire && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = advance & ~rst;
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out       = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
  assign bus.xfer_cnt  = cnt_q;
endmodule
